// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential divider.
//   state_t    - divider control states
//   DEF_WIDTH  - default operand width W (dividend is 2W bits)
//   cnt_width  - iteration counter width, $clog2(W) with a 1-bit floor
// Optional build macro used by the divider files: DIV_SIGNED_EN.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_LO,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  localparam int unsigned DEF_WIDTH = 5;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake bundle of the sequential divider.
//   start, din, divisor                            - requester -> divider
//   busy, done, quotient, remainder,
//   div_by_zero, overflow                          - divider -> requester
// master: requester side; slave: divider side.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, din, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, din, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/div_datapath.sv
// div_datapath: operand capture, restoring shift/subtract core and sign fix.
//   i_cap_hi / i_cap_lo  capture dividend halves (divisor with the high half)
//   i_prep               load partial remainder with |dividend|
//   i_iter               one restoring-division step
//   o_dvs_zero, o_hi_ovf early-exit conditions evaluated in PREP
//   o_quot, o_rem        sign-corrected results, valid in FIX
//   o_fix_ovf            signed quotient out of range, valid in FIX
// DIV_SIGNED_EN selects two's-complement operands; otherwise unsigned.
module div_datapath
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cap_hi,
  input  logic             i_cap_lo,
  input  logic             i_prep,
  input  logic             i_iter,
  input  logic [WIDTH-1:0] i_din,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_dvs_zero,
  output logic             o_hi_ovf,
  output logic             o_fix_ovf,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);

  logic [2*WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  // High half: partial remainder; low half: remaining dividend bits shifting
  // out while quotient bits shift in.
  logic [2*WIDTH-1:0] r_pr;

  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [2*WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH:0]     w_upper;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_qm;
  logic [WIDTH-1:0]   w_rm;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
  logic w_qneg;
  assign w_dvd_neg = r_dvd[2*WIDTH-1];
  assign w_dvs_neg = r_dvs[WIDTH-1];
`else
  assign w_dvd_neg = 1'b0;
  assign w_dvs_neg = 1'b0;
`endif

  assign w_dvd_mag  = w_dvd_neg ? -r_dvd : r_dvd;
  assign w_dvs_mag  = w_dvs_neg ? -r_dvs : r_dvs;
  assign o_dvs_zero = (r_dvs == '0);
  assign o_hi_ovf   = (w_dvd_mag[2*WIDTH-1:WIDTH] >= w_dvs_mag);

  // High half stays below |divisor|, so W+1 bits hold the shifted value and
  // the trial difference's MSB is its sign.
  assign w_upper = r_pr[2*WIDTH-1:WIDTH-1];
  assign w_trial = w_upper - {1'b0, w_dvs_mag};

  assign w_qm = r_pr[WIDTH-1:0];
  assign w_rm = r_pr[2*WIDTH-1:WIDTH];

`ifdef DIV_SIGNED_EN
  assign w_qneg    = w_dvd_neg ^ w_dvs_neg;
  assign o_quot    = w_qneg ? -w_qm : w_qm;
  assign o_rem     = w_dvd_neg ? -w_rm : w_rm;
  assign o_fix_ovf = w_qneg ? (w_qm > HALF) : (w_qm >= HALF);
`else
  assign o_quot    = w_qm;
  assign o_rem     = w_rm;
  assign o_fix_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd <= '0;
      r_dvs <= '0;
      r_pr  <= '0;
    end else begin
      if (i_cap_hi) begin
        r_dvd[2*WIDTH-1:WIDTH] <= i_din;
        r_dvs                  <= i_divisor;
      end
      if (i_cap_lo) begin
        r_dvd[WIDTH-1:0] <= i_din;
      end
      if (i_prep) begin
        r_pr <= w_dvd_mag;
      end else if (i_iter) begin
        if (!w_trial[WIDTH]) begin
          r_pr <= {w_trial[WIDTH-1:0], r_pr[WIDTH-2:0], 1'b1};
        end else begin
          r_pr <= {r_pr[2*WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, 2W-bit dividend / W-bit divisor.
//   clk, rst  clock and synchronous active-high reset
//   bus       seq_divider_if.slave: start/din/divisor in; busy/done/
//             quotient/remainder/div_by_zero/overflow out (all registered)
// Dividend arrives as high half (with start) then low half next cycle.
// DIV_SIGNED_EN selects two's-complement operands; otherwise unsigned.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;
  logic             r_ovf;

  logic             w_cap_hi;
  logic             w_dvs_zero;
  logic             w_hi_ovf;
  logic             w_fix_ovf;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  assign w_cap_hi = (r_state == IDLE) && bus.start;

  div_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .rst        (rst),
    .i_cap_hi   (w_cap_hi),
    .i_cap_lo   (r_state == LOAD_LO),
    .i_prep     (r_state == PREP),
    .i_iter     (r_state == ITER),
    .i_din      (bus.din),
    .i_divisor  (bus.divisor),
    .o_dvs_zero (w_dvs_zero),
    .o_hi_ovf   (w_hi_ovf),
    .o_fix_ovf  (w_fix_ovf),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_busy  <= 1'b1;
            r_state <= LOAD_LO;
          end
        end
        LOAD_LO: r_state <= PREP;
        PREP: begin
          // Results are cleared here; on early exit they stay zero.
          r_quot <= '0;
          r_rem  <= '0;
          r_dbz  <= 1'b0;
          r_ovf  <= 1'b0;
          if (w_dvs_zero) begin
            r_dbz   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (w_hi_ovf) begin
            r_ovf   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt   <= CW'(WIDTH - 1);
            r_state <= ITER;
          end
        end
        ITER: begin
          if (r_cnt == '0) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          if (w_fix_ovf) begin
            r_ovf <= 1'b1;
          end else begin
            r_quot <= w_quot;
            r_rem  <= w_rem;
          end
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;

endmodule
